keypad_emulator: RTL and testbench

//  Models a 4x4 matrix keypad electrically: responds to the row scan from the keypad

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_emulator_if.sv | 38 +++
 rtl/kp_cycle_timer.sv | 40 ++++
 rtl/keypad_emulator.sv | 178 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : keypad_pkg                                                     |
// | Purpose : Shared types and the 4x4 keypad key map used by the keypad     |
// |           emulator and by the keypad scanner decoder.                    |
// | Contents: key_code_t, emu_state_t, KEY_ROW / KEY_COL map tables,         |
// |           kp_max4() helper for sizing the emulator timer.                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    PRESS      = 3'd2,
    BOUNCE_OUT = 3'd3,
    RELEASE    = 3'd4
  } emu_state_t;

  // Physical layout (row, col):
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E 0 F D
  // Tables are indexed by key code 0x0..0xF.
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0,   // 0 1 2 3
    2'd1, 2'd1, 2'd1, 2'd2,   // 4 5 6 7
    2'd2, 2'd2, 2'd0, 2'd1,   // 8 9 A B
    2'd2, 2'd3, 2'd3, 2'd3    // C D E F
  };

  localparam logic [1:0] KEY_COL [16] = '{
    2'd1, 2'd0, 2'd1, 2'd2,   // 0 1 2 3
    2'd0, 2'd1, 2'd2, 2'd0,   // 4 5 6 7
    2'd1, 2'd2, 2'd3, 2'd3,   // 8 9 A B
    2'd3, 2'd3, 2'd0, 2'd2    // C D E F
  };

  function automatic int kp_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_emulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: keypad_emulator_if                                            |
// | Purpose  : Bundles the keypad matrix lines and the press-command port    |
// |            of the keypad emulator.                                       |
// | Signals  : filas[3:0]    row drive from scanner, active-low              |
// |            columnas[3:0] column sense to scanner, active-low             |
// |            cmd_key[3:0]  key code to press                               |
// |            cmd_valid     command request                                 |
// |            cmd_ready     emulator can accept a command                   |
// |            busy          emulator is executing a press                   |
// |            press_active  contact state (1 = closed)                      |
// | Modports : master = scanner / command source, slave = emulator           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic [3:0] filas;
  logic [3:0] columnas;
  key_code_t  cmd_key;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       press_active;

  modport master (
    output filas, cmd_key, cmd_valid,
    input  columnas, cmd_ready, busy, press_active
  );

  modport slave (
    input  filas, cmd_key, cmd_valid,
    output columnas, cmd_ready, busy, press_active
  );

endinterface
`default_nettype wire

// File: rtl/kp_cycle_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : kp_cycle_timer                                                 |
// | Purpose : Loadable down-counter that stops at zero.                      |
// | Ports   : clk         system clock                                       |
// |           rst_n       asynchronous active-low reset (count -> 0)         |
// |           load_i      load load_val_i this cycle (has priority)          |
// |           load_val_i  value to load                                      |
// |           value_o     current count                                      |
// |           done_o      count == 0                                         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module kp_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] value_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign value_o = count_q;
  assign done_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : keypad_emulator                                                |
// | Purpose : Electrical model of a 4x4 matrix keypad. Presses requested     |
// |           through a valid/ready command port close the matching contact  |
// |           for HOLD_CYCLES, then force it open for GAP_CYCLES. The column |
// |           lines answer the row scan combinationally, like a real switch. |
// | Ports   : clk    system clock                                            |
// |           rst_n  asynchronous active-low reset                           |
// |           kp     keypad_emulator_if.slave (matrix + command port)        |
// | Config  : KEYPAD_EMU_BOUNCE_EN - adds contact bounce at make and break   |
// |           (BOUNCE_TOGGLES toggles, one every BOUNCE_CYCLES).             |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module keypad_emulator import keypad_pkg::*; #(
  parameter int HOLD_CYCLES    = 540000,
  parameter int GAP_CYCLES     = 270000,
  parameter int BOUNCE_CYCLES  = 2700,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_emulator_if.slave  kp
);

  localparam int c_BOUNCE_LEN = BOUNCE_TOGGLES * BOUNCE_CYCLES;
  // Sized so every value the single timer is ever loaded with fits.
  localparam int c_MAX_LOAD   = kp_max4(HOLD_CYCLES, GAP_CYCLES, c_BOUNCE_LEN, BOUNCE_CYCLES);
  localparam int TW           = $clog2(c_MAX_LOAD + 1);

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit c_USE_BOUNCE = (BOUNCE_TOGGLES > 0);
`else
  localparam bit c_USE_BOUNCE = 1'b0;
`endif

  // Loads are N-1 because the loading edge already starts the first cycle.
  localparam logic [TW-1:0] c_HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] c_GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] c_BNC_LOAD   = TW'(c_BOUNCE_LEN - 1);
  localparam logic [TW-1:0] c_BNC_PERIOD = TW'(BOUNCE_CYCLES);

  emu_state_t      state_q, state_d;
  logic            press_active_q, press_active_d;
  key_code_t       key_q, key_d;

  logic            w_load;
  logic [TW-1:0]   w_load_val;
  logic [TW-1:0]   w_timer_value;
  logic            w_timer_done;
  logic            w_accept;
  logic            w_bounce_edge;
  logic [3:0]      w_cols;

  kp_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .value_o    (w_timer_value),
    .done_o     (w_timer_done)
  );

  assign w_accept = kp.cmd_valid && (state_q == IDLE);

  // The timer counts the remaining cycles of a bounce state; a new
  // BOUNCE_CYCLES slot starts next cycle whenever the remainder is a multiple.
  assign w_bounce_edge = ((w_timer_value % c_BNC_PERIOD) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      press_active_q <= 1'b0;
      key_q          <= '0;
    end else begin
      state_q        <= state_d;
      press_active_q <= press_active_d;
      key_q          <= key_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    press_active_d = press_active_q;
    key_d          = key_q;
    w_load         = 1'b0;
    w_load_val     = '0;

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          key_d          = kp.cmd_key;
          press_active_d = 1'b1;
          w_load         = 1'b1;
          if (c_USE_BOUNCE) begin
            state_d    = BOUNCE_IN;
            w_load_val = c_BNC_LOAD;
          end else begin
            state_d    = PRESS;
            w_load_val = c_HOLD_LOAD;
          end
        end
      end

      BOUNCE_IN: begin
        if (w_timer_done) begin
          state_d        = PRESS;
          press_active_d = 1'b1;
          w_load         = 1'b1;
          w_load_val     = c_HOLD_LOAD;
        end else if (w_bounce_edge) begin
          press_active_d = !press_active_q;
        end
      end

      PRESS: begin
        if (w_timer_done) begin
          press_active_d = 1'b0;
          if (c_USE_BOUNCE) begin
            state_d    = BOUNCE_OUT;
            w_load     = 1'b1;
            w_load_val = c_BNC_LOAD;
          end else if (GAP_CYCLES > 0) begin
            state_d    = RELEASE;
            w_load     = 1'b1;
            w_load_val = c_GAP_LOAD;
          end else begin
            state_d    = IDLE;
          end
        end
      end

      BOUNCE_OUT: begin
        if (w_timer_done) begin
          press_active_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d    = RELEASE;
            w_load     = 1'b1;
            w_load_val = c_GAP_LOAD;
          end else begin
            state_d    = IDLE;
          end
        end else if (w_bounce_edge) begin
          press_active_d = !press_active_q;
        end
      end

      RELEASE: begin
        if (w_timer_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d        = IDLE;
        press_active_d = 1'b0;
      end
    endcase
  end

  // Only the pressed key's column can be pulled low, and only while its row
  // is driven low; any other rows driven low at the same time do not matter.
  always_comb begin
    w_cols = 4'b1111;
    if (press_active_q && !kp.filas[KEY_ROW[key_q]]) begin
      w_cols[KEY_COL[key_q]] = 1'b0;
    end
  end

  assign kp.columnas     = w_cols;
  assign kp.cmd_ready    = (state_q == IDLE);
  assign kp.busy         = (state_q != IDLE);
  assign kp.press_active = press_active_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_keypad_emulator                                             |
// | Purpose : Self-checking bench for keypad_emulator (HOLD=8, GAP=4,        |
// |           BOUNCE_CYCLES=2, BOUNCE_TOGGLES=2). Expected column, contact   |
// |           and handshake values are queued as stimulus is driven and      |
// |           compared when the cycle is sampled.                            |
// | Config  : honours KEYPAD_EMU_BOUNCE_EN like the design.                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int BC   = 2;
  localparam int BT   = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BL   = BT * BC;
`else
  localparam int BL   = 0;
`endif
  // Accept-to-accept period: 13 cycles plain, 21 with bounce.
  localparam int PERIOD = HOLD + GAP + 1 + 2 * BL;

  typedef struct packed {
    logic [3:0] cols;
    logic       pa;
    logic       ready;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_mis;
  exp_t sb_q[$];

  // Keypad as seen on the front panel; rows top to bottom, cols left to right.
  logic [3:0] GRID [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  keypad_emulator_if kif ();

  keypad_emulator #(
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP),
    .BOUNCE_CYCLES  (BC),
    .BOUNCE_TOGGLES (BT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_cols(input logic [3:0] key, input logic [3:0] filas, input logic pa);
    logic [3:0] c;
    c = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        if (GRID[r][k] == key && pa && !filas[r]) c[k] = 1'b0;
    return c;
  endfunction

  // Contact state in cycle N+j after an accept at edge N.
  function automatic logic exp_pa(input int j);
    if (j >= 1 && j <= BL)                         return (((j - 1) / BC) % 2) == 0;
    if (j > BL && j <= BL + HOLD)                  return 1'b1;
    if (j > BL + HOLD && j <= 2 * BL + HOLD)       return (((j - BL - HOLD - 1) / BC) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic push_exp(input logic [3:0] cols, input logic pa, input logic ready);
    exp_t e;
    e.cols  = cols;
    e.pa    = pa;
    e.ready = ready;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    check_value({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_value({tag, "_columnas"},  32'(kif.columnas),     32'(e.cols));
    check_value({tag, "_press"},     32'(kif.press_active), 32'(e.pa));
    check_value({tag, "_cmd_ready"}, 32'(kif.cmd_ready),    32'(e.ready));
    check_value({tag, "_busy"},      32'(kif.busy),         32'(!e.ready));
  endtask

  // Returns at a negedge where cmd_ready is high (or the budget expired).
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!kif.cmd_ready && k < 64) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check_value({tag, "_wait_ready"}, 32'(kif.cmd_ready), 32'd1);
  endtask

  // Entered just after the accept edge; ends at the negedge of the first
  // cycle in which the emulator should be idle again.
  task automatic run_window(input logic [3:0] key, input logic [3:0] pat_a,
                            input logic [3:0] pat_b, input string tag);
    for (int j = 1; j <= PERIOD; j++) begin
      logic [3:0] f;
      logic       p;
      f = (j % 2 == 1) ? pat_a : pat_b;
      p = exp_pa(j);
      kif.filas = f;
      push_exp(exp_cols(key, f, p), p, (j == PERIOD));
      @(negedge clk);
      sb_compare($sformatf("%s_c%0d", tag, j));
      if (j < PERIOD) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic press(input logic [3:0] key, input logic [3:0] pat_a, input logic [3:0] pat_b,
                       input bit hold_valid, input logic [3:0] next_key, input string tag);
    kif.cmd_key   = key;
    kif.cmd_valid = 1'b1;
    wait_ready(tag);
    @(posedge clk);
    #1;
    if (hold_valid) kif.cmd_key = next_key;
    else            kif.cmd_valid = 1'b0;
    run_window(key, pat_a, pat_b, tag);
  endtask

  initial begin
    logic [3:0] sweep [4];
    n_vec = 0;
    n_mis = 0;
    sweep = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    rst_n         = 1'b0;
    kif.filas     = 4'b1111;
    kif.cmd_key   = 4'h0;
    kif.cmd_valid = 1'b0;
    #1;
    push_exp(4'b1111, 1'b0, 1'b1);
    sb_compare("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle row sweep: nothing pressed.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      kif.filas = sweep[i];
      push_exp(4'b1111, 1'b0, 1'b1);
      @(negedge clk);
      sb_compare($sformatf("idle_sweep%0d", i));
    end

    // Key 5 on row 1; alternate cycles scan row 2 which must stay silent.
    press(4'h5, 4'b1101, 4'b1011, 1'b0, 4'h0, "key5");

    // Key 0 then key D back-to-back; cmd_key changes while busy and is ignored.
    press(4'h0, 4'b0111, 4'b1110, 1'b1, 4'hD, "key0");
    @(posedge clk);
    #1;
    kif.cmd_valid = 1'b0;
    run_window(4'hD, 4'b0111, 4'b1110, "keyD");

    // Key A with all rows low and then no row driven.
    press(4'hA, 4'b0000, 4'b1111, 1'b0, 4'h0, "keyA");

    // Reset in cycle N+4 of a press of key 6.
    kif.filas     = 4'b1101;
    kif.cmd_key   = 4'h6;
    kif.cmd_valid = 1'b1;
    wait_ready("rstpress");
    @(posedge clk);
    #1;
    kif.cmd_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      push_exp(exp_cols(4'h6, 4'b1101, exp_pa(j)), exp_pa(j), 1'b0);
      @(negedge clk);
      sb_compare($sformatf("rstpress_c%0d", j));
      if (j < 4) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    #1;
    push_exp(4'b1111, 1'b0, 1'b1);
    sb_compare("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      push_exp(4'b1111, 1'b0, 1'b1);
      @(negedge clk);
      sb_compare($sformatf("post_rst%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
